instr_encoder: RTL and testbench

- Program-loader front end and the encoding counterpart of the pipeline's opcode/funct control decoder.
- Accepts symbolic instruction requests (operation select plus fields) over a valid/ready handshake and assembles 32-bit MIPS words.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory, starting at a base address.
- Used by testbenches and boot logic to preload imem before the 5-stage CPU leaves reset.

---
 rtl/instr_encoder.sv | 152 +++++++++++++++
 tb/tb_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instruction requests and streams them through a small FIFO into imem.
// Optional request legality checking is enabled by defining INSTR_ENC_CHECK_EN.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_JR    = 3'd2;
  localparam logic [2:0] OP_LW    = 3'd3;
  localparam logic [2:0] OP_SW    = 3'd4;
  localparam logic [2:0] OP_BEQ   = 3'd5;
  localparam logic [2:0] OP_ORI   = 3'd6;
  localparam logic [2:0] OP_J     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        enc;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty, fifo_full;
  logic               accept, legal, push;
  logic [ADDR_W-1:0]  addr_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign push       = accept && legal;

  // Field packing for each supported operation
  always_comb begin
    enc = '0;
    case (in_op)
      OP_RTYPE: enc = {6'd0, in_rs, in_rt, in_rd, in_shamt, in_funct};
      OP_DIVU:  enc = {6'd0, in_rs, in_rt, 10'd0, 6'd27};
      OP_JR:    enc = {6'd0, in_rs, 15'd0, 6'd8};
      OP_LW:    enc = {6'd35, in_rs, in_rt, in_imm};
      OP_SW:    enc = {6'd43, in_rs, in_rt, in_imm};
      OP_BEQ:   enc = {6'd4, in_rs, in_rt, in_imm};
      OP_ORI:   enc = {6'd13, in_rs, in_rt, in_imm};
      OP_J:     enc = {6'd2, in_target};
      default:  enc = '0;
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  // RTYPE must not alias JR/DIVU funct codes and must name a real destination
  assign legal = !((in_op == OP_RTYPE) &&
                   ((in_funct == 6'd8) || (in_funct == 6'd27) || (in_rd == 5'd0)));

  always_ff @(posedge clk) begin
    if (!rst_n)                 err <= 1'b0;
    else if (accept && !legal)  err <= 1'b1;
  end
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && in_last) state_nxt = S_DRAIN;
      // Leave as soon as the final word is being written this cycle
      S_DRAIN: if (fifo_empty || ((count == CNT_W'(1)) && wr_en)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    if (state == S_LOAD) in_ready = !fifo_full;
    if ((state == S_LOAD) || (state == S_DRAIN)) wr_en = !fifo_empty && !wr_stall;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (wr_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, wr_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= BASE_ADDR;
      word_count <= '0;
    end else if ((state == S_IDLE) && start) begin
      addr_q     <= BASE_ADDR;
      word_count <= '0;
    end else if (wr_en) begin
      addr_q     <= addr_q + ADDR_W'(4);
      word_count <= word_count + ADDR_W'(1);
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = fifo_empty ? 32'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven sessions with a write scoreboard,
// plus stall, address-wrap (second instance) and mid-session reset sequences.
module tb_instr_encoder;

  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
    logic [31:0] word;
    logic        push;
  } req_t;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_last, wr_stall;
  logic [2:0] in_op;
  logic [4:0] in_rs, in_rt, in_rd, in_shamt;
  logic [5:0] in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic in_ready, wr_en, busy, done, err;
  logic [31:0] wr_addr, wr_data, word_count;
  logic in_ready1, wr_en1, busy1, done1, err1;
  logic [31:0] wr_addr1, wr_data1, word_count1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int sess_pushes = 0;
  int wr_idx = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_stall(wr_stall),
    .busy(busy), .done(done), .word_count(word_count), .err(err));

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(BASE1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_stall(wr_stall),
    .busy(busy1), .done(done1), .word_count(word_count1), .err(err1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input req_t r);
    case (r.op)
      3'd0: return {6'd0, r.rs, r.rt, r.rd, r.shamt, r.funct};
      3'd1: return {6'd0, r.rs, r.rt, 10'd0, 6'd27};
      3'd2: return {6'd0, r.rs, 15'd0, 6'd8};
      3'd3: return {6'd35, r.rs, r.rt, r.imm};
      3'd4: return {6'd43, r.rs, r.rt, r.imm};
      3'd5: return {6'd4, r.rs, r.rt, r.imm};
      3'd6: return {6'd13, r.rs, r.rt, r.imm};
      default: return {6'd2, r.target};
    endcase
  endfunction

  function automatic logic model_push(input req_t r);
`ifdef INSTR_ENC_CHECK_EN
    return !((r.op == 3'd0) && ((r.funct == 6'd8) || (r.funct == 6'd27) || (r.rd == 5'd0)));
`else
    return 1'b1;
`endif
  endfunction

  function automatic req_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                              input logic [25:0] target, input logic last, input logic [31:0] word);
    req_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.shamt = 5'd0; r.funct = funct;
    r.imm = imm; r.target = target; r.last = last; r.word = word;
    r.push = model_push(r);
    return r;
  endfunction

  function automatic req_t rnd(input logic last);
    req_t r;
    r.op = 3'($urandom_range(1, 7));
    r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom); r.shamt = 5'($urandom);
    r.funct = 6'($urandom); r.imm = 16'($urandom); r.target = 26'($urandom);
    r.last = last;
    r.word = model_enc(r);
    r.push = model_push(r);
    return r;
  endfunction

  // Write-side scoreboard: both instances must write the same word; addresses differ by base
  always @(negedge clk) begin
    if (wr_en !== wr_en1) begin
      checks++; errors++;
      $display("FAIL wr_en_pair: dut %b, wrap %b", wr_en, wr_en1);
    end
    if (wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      chk("no_write_under_stall", {31'd0, wr_stall}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: data %h addr %h", wr_data, wr_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("wr_data", wr_data, e);
        chk("wr_addr", wr_addr, 32'(wr_idx * 4));
        chk("wr_data_wrap", wr_data1, e);
        chk("wr_addr_wrap", wr_addr1, BASE1 + 32'(wr_idx * 4));
      end
      wr_idx++;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    wr_idx = 0;
    sess_pushes = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input req_t r);
    int n;
    n = 0;
    @(negedge clk);
    in_op = r.op; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd; in_shamt = r.shamt;
    in_funct = r.funct; in_imm = r.imm; in_target = r.target; in_last = r.last;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, expected 1", in_ready, n);
    end else if (r.push) begin
      exp_q.push_back(r.word);
      sess_pushes++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done %b, expected 1", name, done);
    end else if (sess_pushes > 0 && cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_latency: %0d cycles after last write, expected 1", name, cyc - last_wr_cyc);
    end
    chk({name, "_word_count"}, word_count, 32'(sess_pushes));
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_word_count"}, word_count, 32'd0);
    chk({name, "_err"}, {31'd0, err}, 32'd0);
    chk({name, "_wr_data"}, wr_data, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t tbl[6];
    req_t r;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; wr_stall = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0;

    tbl[0] = mk(3'd0, 5'd8, 5'd9, 5'd10, 6'd32, 16'h0, 26'h0, 1'b0, 32'h0109_5020);
    tbl[1] = mk(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0, 32'h0109_001B);
    tbl[2] = mk(3'd2, 5'd31, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0, 32'h03E0_0008);
    tbl[3] = mk(3'd6, 5'd0, 5'd8, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b0, 32'h3408_FFFF);
    tbl[4] = mk(3'd5, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'h0, 1'b0, 32'h1109_FFFF);
    tbl[5] = mk(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b1, 32'h0800_0010);

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Single LW session
    do_start();
    chk("busy_in_load", {31'd0, busy}, 32'd1);
    send(mk(3'd3, 5'd16, 5'd8, 5'd0, 6'd0, 16'd4, 26'h0, 1'b1, 32'h8E08_0004));
    wait_done("lw");

    // Six-op session from the table
    do_start();
    for (int i = 0; i < 6; i++) send(tbl[i]);
    wait_done("table");

    // Stall fills the FIFO; in_ready drops after four accepts
    do_start();
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd(1'b0));
    @(negedge clk);
    in_valid = 1'b1;
    repeat (3) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wr_en", {31'd0, wr_en}, 32'd0);
      chk("stall_word_count", word_count, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wr_stall = 1'b0;
    send(rnd(1'b0));
    send(rnd(1'b1));
    wait_done("stall");

    // Three words: wrap instance crosses the top of the address space
    do_start();
    for (int i = 0; i < 3; i++) send(rnd(i == 2));
    wait_done("wrap");
    chk("wrap_word_count", word_count1, 32'd3);

    // Illegal RTYPE followed by LW
    do_start();
    send(mk(3'd0, 5'd1, 5'd2, 5'd3, 6'd8, 16'h0, 26'h0, 1'b0, 32'h0022_1808));
    send(mk(3'd3, 5'd16, 5'd8, 5'd0, 6'd0, 16'd4, 26'h0, 1'b1, 32'h8E08_0004));
    wait_done("check");
`ifdef INSTR_ENC_CHECK_EN
    chk("check_err", {31'd0, err}, 32'd1);
    chk("check_count", word_count, 32'd1);
`else
    chk("check_err", {31'd0, err}, 32'd0);
    chk("check_count", word_count, 32'd2);
`endif

    // Reset mid-LOAD with two words queued
    do_start();
    wr_stall = 1'b1;
    send(rnd(1'b0));
    send(rnd(1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk_reset_state("midreset");
    rst_n = 1'b1;
    wr_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_idle_wr_en", {31'd0, wr_en}, 32'd0);
    do_start();
    r = rnd(1'b1);
    send(r);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
